// File: rtl/instr_fetch_unit.sv
// Instruction fetch: program counter plus a small prefetch FIFO feeding decode over valid/ready.
// Fetch-to-head latency is 1 cycle. Fetch stalls while the FIFO is full and not popping. Start and redirect flush the FIFO.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_W-1:0] instr_mem_q [FIFO_DEPTH];

  logic flush;
  logic pop;
  logic push;

  assign flush = start | redirect_valid;
  assign pop   = out_valid & out_ready;
  // stop is sampled at the same edge as the fetch, so that fetch is suppressed.
  assign push  = (state_q == ST_RUN) & ~flush & ~stop & ((count_q != CNT_FULL) | pop);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (start) begin
      state_d = ST_RUN;
    end else if (stop) begin
      state_d = ST_IDLE;
    end

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = start ? PC_RST : redirect_addr;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_RST;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr = pc_q;
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory, expected {pc, instr} queue per scenario.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       out_ready;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       busy;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] exp_e;
  int checks = 0;
  int errors = 0;

  assign imem_instr = mem[imem_addr];

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  instr_fetch_unit #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(2), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 8'h00; out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr); end
    checks++; if (out_instr !== 8'h00) begin errors++; $display("FAIL reset_out_instr: got %h want 00", out_instr); end
    checks++; if (out_pc !== 8'h00) begin errors++; $display("FAIL reset_out_pc: got %h want 00", out_pc); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stream();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back({8'h00, 8'h12});
    exp_q.push_back({8'h01, 8'h23});
    exp_q.push_back({8'h02, 8'h19});
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got valid %b want 0 in fetch cycle", out_valid); end
    repeat (3) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL stream_entry: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    checks++; if (out_pc !== 8'h00 || out_instr !== 8'h12) begin errors++; $display("FAIL bp_head: got pc=%h instr=%h want pc=00 instr=12", out_pc, out_instr); end
    checks++; if (imem_addr !== 8'h02) begin errors++; $display("FAIL bp_pc_stall: got %h want 02", imem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (out_pc !== 8'h00 || imem_addr !== 8'h02) begin errors++; $display("FAIL bp_hold: got head pc=%h addr=%h want 00/02", out_pc, imem_addr); end
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({8'(i), mem[i]});
    out_ready = 1'b1;
    repeat (5) begin
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL bp_resume: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back({8'h00, mem[0]});
    exp_q.push_back({8'h01, mem[1]});
    @(negedge clk); start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL redir_pre: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
    end
    // The head shown in the redirect cycle is discarded, not delivered.
    @(negedge clk); redirect_valid = 1'b1; redirect_addr = 8'h80;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(8'h80 + i), mem[8'h80 + i]});
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid %b want 0", out_valid); end
    checks++; if (imem_addr !== 8'h80) begin errors++; $display("FAIL redir_addr: got %h want 80", imem_addr); end
    repeat (3) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL redir_post: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    @(negedge clk); redirect_valid = 1'b1; redirect_addr = 8'hFE; out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      a = 8'(254 + i);
      exp_q.push_back({a, mem[a]});
    end
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_addr: got %h want fe", imem_addr); end
    repeat (4) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL wrap_entry: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
    end
  endtask

  task automatic test_stop();
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stop_valid_kept: got %b want 1", out_valid); end
    checks++; if (imem_addr !== 8'h02) begin errors++; $display("FAIL stop_pc: got %h want 02", imem_addr); end
    repeat (3) @(negedge clk);
    checks++; if (imem_addr !== 8'h02) begin errors++; $display("FAIL stop_pc_frozen: got %h want 02", imem_addr); end
    exp_q.delete();
    exp_q.push_back({8'h00, mem[0]});
    exp_q.push_back({8'h01, mem[1]});
    out_ready = 1'b1;
    repeat (2) begin
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL stop_drain: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
      @(negedge clk);
    end
    repeat (3) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_empty: got valid %b want 0", out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_priority();
    @(negedge clk); start = 1'b1; stop = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h40; out_ready = 1'b0;
    @(negedge clk); start = 1'b0; stop = 1'b0; redirect_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b want 1", busy); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL prio_pc: got %h want 00", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_flush: got valid %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL arst_addr: got %h want 00", imem_addr); end
    #2 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i), mem[i]});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart_busy: got %b want 1", busy); end
    repeat (3) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_e[15:8] || out_instr !== exp_e[7:0]) begin
        errors++; $display("FAIL arst_restart: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_e[15:8], exp_e[7:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 29 + 7) ^ 8'h5A);
    mem[0] = 8'h12;
    mem[1] = 8'h23;
    mem[2] = 8'h19;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_stop();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
